// File: rtl/axi_pkg.sv
// Shared AXI responder definitions: response codes, write FSM states and
// the address decode helper used by both the write and read responders.
package axi_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    WAIT_AW,
    WRITE,
    RESP
  } wr_state_t;

  // Widened to 64 bits so base + span can never wrap for ADDR_W <= 32.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/axi_wr_slave.sv
// Single-beat AXI4-style write responder: accepts AW and W in either order,
// performs one masked write on a synchronous RAM port and returns B.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       MEM_WORDS = 4096
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [DATA_W/8-1:0]          WSTRB,
  input  logic                         WLAST,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  output logic                         mem_wen,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wstrb
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  wr_state_t           state, state_nxt;
  logic                awready_q, wready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;
  logic                last_q;
  logic                aw_fire, w_fire;
  logic                in_range;
  logic [1:0]          resp;

  assign aw_fire = AWVALID & awready_q;
  assign w_fire  = WVALID & wready_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (aw_fire && w_fire) state_nxt = WRITE;
        else if (aw_fire)      state_nxt = WAIT_W;
        else if (w_fire)       state_nxt = WAIT_AW;
      end
      WAIT_W:  if (w_fire)  state_nxt = WRITE;
      WAIT_AW: if (aw_fire) state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    if (BREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_range = addr_in_range(64'(addr_q), 64'(BASE_ADDR),
                             64'(MEM_WORDS) * 64'(STRB_W));
    if (!in_range)   resp = BRESP_DECERR;
    else if (!last_q) resp = BRESP_SLVERR;
    else             resp = BRESP_OKAY;
  end

  // READYs are registered from the next state so they never depend on VALID.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      awready_q <= (state_nxt == IDLE) || (state_nxt == WAIT_AW);
      wready_q  <= (state_nxt == IDLE) || (state_nxt == WAIT_W);
      if (aw_fire) addr_q <= AWADDR;
      if (w_fire) begin
        data_q <= WDATA;
        strb_q <= WSTRB;
        last_q <= WLAST;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = (state == RESP);
  assign BRESP   = (state == RESP) ? resp : '0;

  // Gated by ARESETn so a reset landing on the WRITE cycle suppresses the RAM write.
  assign mem_wen   = ARESETn && (state == WRITE) && (resp == BRESP_OKAY) && (|strb_q);
  assign mem_addr  = IDX_W'((addr_q - BASE_ADDR) >> OFF_W);
  assign mem_wdata = data_q;
  assign mem_wstrb = strb_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed scenarios plus randomized
// transactions scored against a byte-level RAM reference model.
module tb_axi_wr_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, WLAST = 1'b0;
  logic [31:0] AWADDR = '0;
  logic [63:0] WDATA = '0;
  logic [7:0]  WSTRB = '0;
  logic        AWREADY, WREADY, BVALID, mem_wen;
  logic [1:0]  BRESP;
  logic [11:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  int n_checks = 0;
  int n_pass   = 0;
  int wen_total = 0;

  logic [63:0] ram_dut [WORDS] = '{default: '0};
  logic [63:0] ram_ref [WORDS] = '{default: '0};
  int          touched [$];

  always #5 ACLK = ~ACLK;

  axi_wr_slave #(.ADDR_W(32), .DATA_W(64), .BASE_ADDR(32'h8000_0000), .MEM_WORDS(4096)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  // Bench-side RAM attached to the DUT's memory port.
  always @(posedge ACLK) begin
    if (mem_wen) begin
      wen_total <= wen_total + 1;
      for (int i = 0; i < 8; i++)
        if (mem_wstrb[i]) ram_dut[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic l);
    longint unsigned lo = 64'h8000_0000;
    longint unsigned hi = lo + WORDS * 8;
    if (a < lo || a >= hi) return 2'b11;
    if (!l) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] exp_idx(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    return off[14:3];
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int idx = int'(exp_idx(a));
    for (int i = 0; i < 8; i++)
      if (s[i]) ram_ref[idx][8*i +: 8] = d[8*i +: 8];
    touched.push_back(idx);
  endtask

  // Drives one transaction with per-channel delays and records what the DUT did.
  task automatic run_xact(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic l, input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int wens, output int lat_wen,
                          output int lat_b, output logic [11:0] waddr, output logic [63:0] wdat,
                          output logic [7:0] wstb, output int viol, output logic wr_after_w,
                          output bit done);
    bit aw_done = 0, w_done = 0;
    int fire_cyc = -1, w_fire_cyc = -1, bcnt = 0;
    logic [1:0] bfirst = '0;
    resp = '0; wens = 0; lat_wen = -1; lat_b = -1; waddr = '0; wdat = '0; wstb = '0;
    viol = 0; wr_after_w = 1'b1; done = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      AWVALID = !aw_done && cyc >= aw_dly; AWADDR = a;
      WVALID  = !w_done && cyc >= w_dly;   WDATA = d; WSTRB = s; WLAST = l;
      if (BVALID) bcnt++;
      BREADY = BVALID && bcnt > b_dly;
      @(negedge ACLK);
      if (w_fire_cyc >= 0 && cyc == w_fire_cyc + 1) wr_after_w = WREADY;
      if (mem_wen) begin
        wens++; lat_wen = cyc - fire_cyc; waddr = mem_addr; wdat = mem_wdata; wstb = mem_wstrb;
      end
      if (BVALID && bcnt == 1) bfirst = BRESP;
      if (BVALID && (BRESP !== bfirst || AWREADY || WREADY)) viol++;
      if (BVALID && BREADY) begin resp = BRESP; lat_b = cyc - fire_cyc; done = 1; end
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) begin w_done = 1; w_fire_cyc = cyc; end
      if (aw_done && w_done && fire_cyc < 0) fire_cyc = cyc;
      @(posedge ACLK); #1;
    end
    AWVALID = 0; WVALID = 0; BREADY = 0;
  endtask

  logic [1:0] r; int wens, lw, lb, viol; logic [11:0] wa; logic [63:0] wd; logic [7:0] ws;
  logic wraw; bit dn;

  task automatic test_reset();
    ARESETn = 0;
    repeat (3) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY, BVALID, BRESP, mem_wen, mem_addr, mem_wdata, mem_wstrb} !== '0)
      $display("FAIL reset_outputs: got aw=%b w=%b bv=%b br=%b wen=%b addr=%h, required all 0",
               AWREADY, WREADY, BVALID, BRESP, mem_wen, mem_addr);
    else n_pass++;
    ARESETn = 1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY} !== 2'b11) $display("FAIL reset_release_ready: got %b required 11", {AWREADY, WREADY});
    else n_pass++;
    @(posedge ACLK); #1;
  endtask

  task automatic test_joint();
    run_xact(32'h8000_0010, 64'h1122334455667788, 8'hFF, 1'b1, 0, 0, 0,
             r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
    ref_write(32'h8000_0010, 64'h1122334455667788, 8'hFF);
    n_checks++; if (!dn) $display("FAIL joint_timeout: no B handshake within bound"); else n_pass++;
    n_checks++; if (r !== 2'b00) $display("FAIL joint_bresp: got %b required 00", r); else n_pass++;
    n_checks++; if (wens !== 1 || lw !== 1) $display("FAIL joint_wen: got count %0d lat %0d required 1/1", wens, lw); else n_pass++;
    n_checks++; if (lb !== 2) $display("FAIL joint_b_latency: got %0d required 2", lb); else n_pass++;
    n_checks++; if (wa !== 12'd2) $display("FAIL joint_addr: got %0d required 2", wa); else n_pass++;
    n_checks++; if (wd !== 64'h1122334455667788 || ws !== 8'hFF)
      $display("FAIL joint_data: got %h/%h required 1122334455667788/ff", wd, ws); else n_pass++;
  endtask

  task automatic test_split();
    run_xact(32'h8000_0008, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F, 1'b1, 3, 0, 0,
             r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
    ref_write(32'h8000_0008, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F);
    n_checks++; if (wraw !== 1'b0) $display("FAIL split_wready_after_w: got %b required 0", wraw); else n_pass++;
    n_checks++; if (wens !== 1 || lw !== 1 || lb !== 2)
      $display("FAIL split_w_first_latency: got wen %0d lat %0d b %0d required 1/1/2", wens, lw, lb); else n_pass++;
    n_checks++; if (wa !== 12'd1 || ws !== 8'h0F || r !== 2'b00)
      $display("FAIL split_w_first_fields: got addr %0d strb %h resp %b required 1/0f/00", wa, ws, r); else n_pass++;
    run_xact(32'h8000_0105, 64'h0123_4567_89AB_CDEF, 8'hA5, 1'b1, 0, 2, 0,
             r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
    ref_write(32'h8000_0105, 64'h0123_4567_89AB_CDEF, 8'hA5);
    n_checks++; if (wens !== 1 || lw !== 1 || lb !== 2 || wa !== 12'd32 || r !== 2'b00)
      $display("FAIL split_aw_first: got wen %0d lat %0d b %0d addr %0d resp %b required 1/1/2/32/00",
               wens, lw, lb, wa, r); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{32'h7FFF_FFF8, 32'h8000_8000, 32'h8000_0100, 32'hFFFF_FFF8, 32'h8000_0200};
    logic        lasts [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  rx;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] s = (i == 4) ? 8'h00 : 8'hFF;
      rx = exp_resp(addrs[i], lasts[i]);
      run_xact(addrs[i], 64'h5555_AAAA_5555_AAAA, s, lasts[i], 0, 0, 0,
               r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
      n_checks++;
      if (r !== rx || wens !== 0 || !dn)
        $display("FAIL error_case_%0d: got resp %b wen %0d done %0d required resp %b wen 0 done 1",
                 i, r, wens, dn, rx);
      else n_pass++;
    end
    // Last word of the decoded range is still OKAY.
    run_xact(32'h8000_7FFF, 64'h7777_8888_9999_AAAA, 8'h81, 1'b1, 1, 1, 0,
             r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
    ref_write(32'h8000_7FFF, 64'h7777_8888_9999_AAAA, 8'h81);
    n_checks++;
    if (r !== 2'b00 || wens !== 1 || wa !== 12'd4095)
      $display("FAIL top_of_range: got resp %b wen %0d addr %0d required 00/1/4095", r, wens, wa);
    else n_pass++;
  endtask

  task automatic test_bready_hold();
    run_xact(32'h8000_8008, 64'h0, 8'hFF, 1'b1, 0, 0, 5,
             r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
    n_checks++; if (viol !== 0) $display("FAIL bhold_stable: got %0d unstable cycles required 0", viol); else n_pass++;
    n_checks++; if (lb !== 7 || r !== 2'b11) $display("FAIL bhold_latency: got lat %0d resp %b required 7/11", lb, r); else n_pass++;
    @(negedge ACLK);
    n_checks++; if ({AWREADY, WREADY, BVALID} !== 3'b110)
      $display("FAIL bhold_idle_after: got %b required 110", {AWREADY, WREADY, BVALID}); else n_pass++;
    @(posedge ACLK); #1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a; logic [63:0] d; logic [7:0] s; logic l; logic [1:0] rx; int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7)       a = BASE + $urandom_range(0, 32767);
      else if (kind == 7) a = BASE - 1 - $urandom_range(0, 999);
      else if (kind == 8) a = BASE + 32768 + $urandom_range(0, 999);
      else                a = $urandom;
      d = {$urandom, $urandom};
      s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      l = ($urandom_range(0, 7) != 0);
      rx = exp_resp(a, l);
      run_xact(a, d, s, l, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               r, wens, lw, lb, wa, wd, ws, viol, wraw, dn);
      n_checks++;
      if (!dn || r !== rx || wens !== ((rx == 2'b00 && s != 0) ? 1 : 0))
        $display("FAIL rand_%0d: addr %h got resp %b wen %0d done %0d required resp %b wen %0d",
                 t, a, r, wens, dn, rx, (rx == 2'b00 && s != 0) ? 1 : 0);
      else n_pass++;
      if (rx == 2'b00) ref_write(a, d, s);
    end
    @(posedge ACLK); #1;
    foreach (touched[k]) begin
      n_checks++;
      if (ram_dut[touched[k]] !== ram_ref[touched[k]])
        $display("FAIL ram_word_%0d: got %h required %h", touched[k], ram_dut[touched[k]], ram_ref[touched[k]]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int base_wens = wen_total;
    int bad = 0;
    AWVALID = 1; AWADDR = 32'h8000_0040;
    @(posedge ACLK); #1;
    AWVALID = 0; ARESETn = 0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY, BVALID, BRESP, mem_wen, mem_addr, mem_wdata, mem_wstrb} !== '0)
      $display("FAIL reset_in_wait_w: outputs not all 0 (aw=%b w=%b addr=%h)", AWREADY, WREADY, mem_addr);
    else n_pass++;
    ARESETn = 1;
    @(posedge ACLK); #1;
    AWVALID = 1; WVALID = 1; AWADDR = 32'h8000_0048; WDATA = 64'hFFFF_0000_FFFF_0000; WSTRB = 8'hFF; WLAST = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARESETn = 0;
    @(negedge ACLK);
    n_checks++;
    if (mem_wen !== 1'b0) $display("FAIL reset_in_write_wen: got %b required 0", mem_wen); else n_pass++;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY, BVALID, BRESP, mem_wen, mem_addr, mem_wdata, mem_wstrb} !== '0)
      $display("FAIL reset_in_write: outputs not all 0 (aw=%b w=%b bv=%b)", AWREADY, WREADY, BVALID);
    else n_pass++;
    ARESETn = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (BVALID || mem_wen) bad++;
    end
    n_checks++;
    if (bad != 0 || wen_total != base_wens)
      $display("FAIL reset_discard: got %0d stray cycles %0d extra writes required 0/0", bad, wen_total - base_wens);
    else n_pass++;
    n_checks++;
    if ({AWREADY, WREADY} !== 2'b11) $display("FAIL reset_mid_idle: got %b required 11", {AWREADY, WREADY});
    else n_pass++;
    @(posedge ACLK); #1;
  endtask

  initial begin
    test_reset();
    test_joint();
    test_split();
    test_errors();
    test_bready_hold();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
